// File: rtl/tlc_input_conditioner.sv
// Front end for the traffic light controller: sensor synchronise/debounce, minute-of-day clock, peak flag.
// Optional macro SENSOR_HOLD_EN stretches each sensor release by HOLD_CYCLES cycles.
module tlc_input_conditioner #(
  parameter int DEB_CYCLES    = 8,
  parameter int TICKS_PER_MIN = 60,
  parameter int PEAK1_START   = 480,
  parameter int PEAK1_END     = 600,
  parameter int PEAK2_START   = 1020,
  parameter int PEAK2_END     = 1140,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sensor1_raw,
  input  logic        sensor2_raw,
  input  logic        peak_force,
  input  logic        time_load,
  input  logic [10:0] time_load_val,
  output logic        sensor1,
  output logic        sensor2,
  output logic        peak,
  output logic [10:0] minute_of_day,
  output logic        minute_tick
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(TICKS_PER_MIN);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  // A window with START >= END is disabled; windows never wrap past midnight.
  function automatic logic in_window(input logic [10:0] m, input int s, input int e);
    return (s < e) && (int'(m) >= s) && (int'(m) < e);
  endfunction

  logic [1:0] raw_s;
  logic [1:0] sens_s;

  assign raw_s   = {sensor2_raw, sensor1_raw};
  assign sensor1 = sens_s[0];
  assign sensor2 = sens_s[1];

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          meta_r;
    logic          sync_r;
    logic          deb_r;
    logic          deb_nxt_s;
    logic [DW-1:0] dcnt_r;
    logic [DW-1:0] dcnt_nxt_s;

    // Two-flop synchroniser for the asynchronous raw sensor
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_r <= 1'b0;
        sync_r <= 1'b0;
      end else begin
        meta_r <= raw_s[i];
        sync_r <= meta_r;
      end
    end

    // Debounce next-state: any agreement with the output restarts the count
    always_comb begin
      deb_nxt_s  = deb_r;
      dcnt_nxt_s = '0;
      if (sync_r == deb_r) begin
        dcnt_nxt_s = '0;
      end else if (dcnt_r == DW'(DEB_CYCLES - 1)) begin
        deb_nxt_s  = ~deb_r;
        dcnt_nxt_s = '0;
      end else begin
        dcnt_nxt_s = dcnt_r + DW'(1);
      end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        deb_r  <= 1'b0;
        dcnt_r <= '0;
      end else begin
        deb_r  <= deb_nxt_s;
        dcnt_r <= dcnt_nxt_s;
      end
    end

`ifdef SENSOR_HOLD_EN
    logic          out_r;
    logic [HW-1:0] hcnt_r;

    // Release stretch; a debounced re-assertion cancels the hold without a glitch
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_r  <= 1'b0;
        hcnt_r <= '0;
      end else if (deb_nxt_s) begin
        out_r  <= 1'b1;
        hcnt_r <= '0;
      end else if (deb_r) begin
        out_r  <= (HOLD_CYCLES != 0);
        hcnt_r <= HW'(HOLD_CYCLES);
      end else if (hcnt_r == HW'(1)) begin
        out_r  <= 1'b0;
        hcnt_r <= '0;
      end else if (hcnt_r != '0) begin
        hcnt_r <= hcnt_r - HW'(1);
      end else begin
        out_r  <= 1'b0;
      end
    end

    assign sens_s[i] = out_r;
`else
    assign sens_s[i] = deb_r;
`endif
  end

`ifndef SENSOR_HOLD_EN
  // HOLD_CYCLES and HW only matter for the release stretch
  logic hold_unused_s;
  assign hold_unused_s = (HOLD_CYCLES != 0) && (HW != 0);
`endif

  logic [PW-1:0] pcnt_r;
  logic [10:0]   minute_r;
  logic          tick_r;
  logic          peak_r;
  logic          wrap_s;
  logic [10:0]   load_val_s;
  logic [10:0]   m_next_s;

  // Next minute value: a load beats a coincident prescaler wrap
  always_comb begin
    wrap_s     = (pcnt_r == PW'(TICKS_PER_MIN - 1));
    load_val_s = (time_load_val > 11'd1439) ? 11'd0 : time_load_val;
    m_next_s   = minute_r;
    if (time_load) begin
      m_next_s = load_val_s;
    end else if (wrap_s) begin
      m_next_s = (minute_r == 11'd1439) ? 11'd0 : minute_r + 11'd1;
    end else begin
      m_next_s = minute_r;
    end
  end

  // Prescaler, minute clock, tick and peak registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_r   <= '0;
      minute_r <= 11'd0;
      tick_r   <= 1'b0;
      peak_r   <= 1'b0;
    end else begin
      if (time_load || wrap_s) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
      end
      minute_r <= m_next_s;
      tick_r   <= wrap_s && !time_load;
      peak_r   <= peak_force
                | in_window(m_next_s, PEAK1_START, PEAK1_END)
                | in_window(m_next_s, PEAK2_START, PEAK2_END);
    end
  end

  assign minute_of_day = minute_r;
  assign minute_tick   = tick_r;
  assign peak          = peak_r;

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// Directed self-checking bench for tlc_input_conditioner (DEB_CYCLES=8, TICKS_PER_MIN=4, HOLD_CYCLES=16).
module tb_tlc_input_conditioner;

`ifdef SENSOR_HOLD_EN
  localparam int FALL_LAT = 26;
`else
  localparam int FALL_LAT = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sensor1_raw;
  logic        sensor2_raw;
  logic        peak_force;
  logic        time_load;
  logic [10:0] time_load_val;
  logic        sensor1;
  logic        sensor2;
  logic        peak;
  logic [10:0] minute_of_day;
  logic        minute_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  tlc_input_conditioner #(
    .DEB_CYCLES   (8),
    .TICKS_PER_MIN(4),
    .HOLD_CYCLES  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor1_raw  (sensor1_raw),
    .sensor2_raw  (sensor2_raw),
    .peak_force   (peak_force),
    .time_load    (time_load),
    .time_load_val(time_load_val),
    .sensor1      (sensor1),
    .sensor2      (sensor2),
    .peak         (peak),
    .minute_of_day(minute_of_day),
    .minute_tick  (minute_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [10:0] v);
    time_load     = 1'b1;
    time_load_val = v;
    step();
    time_load     = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({sensor1, sensor2, peak, minute_tick, minute_of_day} !== 15'd0) begin
      tests_failed++;
      $display("FAIL initial_reset: got s1=%b s2=%b pk=%b tk=%b min=%0d, expected all 0", sensor1, sensor2, peak, minute_tick, minute_of_day);
    end
    reset = 1'b1;
    step();
    sensor1_raw = 1'b1;
    sensor2_raw = 1'b1;
    repeat (11) step();
    load_time(11'd500);
    tests_run++;
    if ({sensor1, sensor2, peak, minute_of_day} !== {1'b1, 1'b1, 1'b1, 11'd500}) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got s1=%b s2=%b pk=%b min=%0d, expected 1 1 1 500", sensor1, sensor2, peak, minute_of_day);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({sensor1, sensor2, peak, minute_tick, minute_of_day} !== 15'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got s1=%b s2=%b pk=%b tk=%b min=%0d, expected all 0", sensor1, sensor2, peak, minute_tick, minute_of_day);
    end
    sensor1_raw = 1'b0;
    sensor2_raw = 1'b0;
    #2 reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      tests_run++;
      if (minute_tick !== (k == 4) || minute_of_day !== ((k == 4) ? 11'd1 : 11'd0)) begin
        tests_failed++;
        $display("FAIL first_tick edge %0d: got tick=%b min=%0d, expected tick=%b min=%0d", k, minute_tick, minute_of_day, (k == 4), (k == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_debounce();
    sensor1_raw = 1'b1;
    repeat (5) step();
    sensor1_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      tests_run++;
      if (sensor1 !== 1'b0 || sensor2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL short_pulse cycle %0d: got s1=%b s2=%b, expected 0 0", k, sensor1, sensor2);
      end
    end
    sensor1_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests_run++;
      if (sensor1 !== (k == 10) || sensor2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL rise_latency cycle %0d: got s1=%b s2=%b, expected s1=%b s2=0", k, sensor1, sensor2, (k == 10));
      end
    end
    repeat (3) step();
  endtask

  task automatic test_sensor_release();
    sensor1_raw = 1'b0;
    for (int k = 1; k <= FALL_LAT; k++) begin
      step();
      tests_run++;
      if (sensor1 !== (k < FALL_LAT)) begin
        tests_failed++;
        $display("FAIL release cycle %0d: got s1=%b, expected %b", k, sensor1, (k < FALL_LAT));
      end
    end
  endtask

  task automatic test_time_load_peak();
    load_time(11'd479);
    tests_run++;
    if (minute_of_day !== 11'd479 || peak !== 1'b0 || minute_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_479: got min=%0d pk=%b tk=%b, expected 479 0 0", minute_of_day, peak, minute_tick);
    end
    repeat (3) step();
    tests_run++;
    if (minute_of_day !== 11'd479 || minute_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_479: got min=%0d tk=%b, expected 479 0", minute_of_day, minute_tick);
    end
    step();
    tests_run++;
    if (minute_of_day !== 11'd480 || peak !== 1'b1 || minute_tick !== 1'b1) begin
      tests_failed++;
      $display("FAIL enter_peak1: got min=%0d pk=%b tk=%b, expected 480 1 1", minute_of_day, peak, minute_tick);
    end
    load_time(11'd599);
    tests_run++;
    if (peak !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_599_peak: got %b, expected 1", peak);
    end
    repeat (4) step();
    tests_run++;
    if (minute_of_day !== 11'd600 || peak !== 1'b0 || minute_tick !== 1'b1) begin
      tests_failed++;
      $display("FAIL leave_peak1: got min=%0d pk=%b tk=%b, expected 600 0 1", minute_of_day, peak, minute_tick);
    end
  endtask

  task automatic test_midnight();
    load_time(11'd1439);
    tests_run++;
    if (minute_of_day !== 11'd1439 || peak !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_1439: got min=%0d pk=%b, expected 1439 0", minute_of_day, peak);
    end
    repeat (4) step();
    tests_run++;
    if (minute_of_day !== 11'd0 || minute_tick !== 1'b1 || peak !== 1'b0) begin
      tests_failed++;
      $display("FAIL midnight_wrap: got min=%0d tk=%b pk=%b, expected 0 1 0", minute_of_day, minute_tick, peak);
    end
    load_time(11'd1500);
    tests_run++;
    if (minute_of_day !== 11'd0) begin
      tests_failed++;
      $display("FAIL load_1500: got %0d, expected 0", minute_of_day);
    end
    load_time(11'd1020);
    tests_run++;
    if (peak !== 1'b1) begin
      tests_failed++;
      $display("FAIL peak2_start: got %b, expected 1", peak);
    end
    load_time(11'd1139);
    tests_run++;
    if (peak !== 1'b1) begin
      tests_failed++;
      $display("FAIL peak2_last: got %b, expected 1", peak);
    end
    load_time(11'd1140);
    tests_run++;
    if (peak !== 1'b0) begin
      tests_failed++;
      $display("FAIL peak2_end: got %b, expected 0", peak);
    end
  endtask

  task automatic test_load_vs_tick();
    load_time(11'd50);
    repeat (3) step();
    load_time(11'd100);
    tests_run++;
    if (minute_of_day !== 11'd100 || minute_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_beats_tick: got min=%0d tk=%b, expected 100 0", minute_of_day, minute_tick);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      tests_run++;
      if (minute_tick !== (k == 4) || minute_of_day !== ((k == 4) ? 11'd101 : 11'd100)) begin
        tests_failed++;
        $display("FAIL prescale_restart edge %0d: got tk=%b min=%0d, expected tk=%b min=%0d", k, minute_tick, minute_of_day, (k == 4), (k == 4) ? 101 : 100);
      end
    end
  endtask

  task automatic test_peak_force();
    load_time(11'd200);
    tests_run++;
    if (peak !== 1'b0) begin
      tests_failed++;
      $display("FAIL peak_off_200: got %b, expected 0", peak);
    end
    peak_force = 1'b1;
    step();
    tests_run++;
    if (peak !== 1'b1) begin
      tests_failed++;
      $display("FAIL force_on: got %b, expected 1", peak);
    end
    peak_force = 1'b0;
    step();
    tests_run++;
    if (peak !== 1'b0) begin
      tests_failed++;
      $display("FAIL force_off: got %b, expected 0", peak);
    end
  endtask

  initial begin
    reset         = 1'b0;
    sensor1_raw   = 1'b0;
    sensor2_raw   = 1'b0;
    peak_force    = 1'b0;
    time_load     = 1'b0;
    time_load_val = 11'd0;
    #11;
    test_reset();
    test_debounce();
    test_sensor_release();
    test_time_load_peak();
    test_midnight();
    test_load_vs_tick();
    test_peak_force();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
